// File: rtl/vsi_dram_scrubber.sv
// vsi_dram_scrubber: zero-fills DRAM [0, MAX_ADDR) one AXI write burst at a time
module vsi_dram_scrubber #(
  parameter logic [63:0] MAX_ADDR  = 64'h4_0000_0000,
  parameter int          BURST_LEN = 63,
  parameter logic [15:0] AXI_ID    = 16'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scrb_enable,
  output logic [63:0]  scrb_addr,
  output logic [2:0]   scrb_state,
  output logic         scrb_done,
  output logic         scrb_err,
  output logic [15:0]  awid,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [15:0]  wid,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [15:0]  bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;
  localparam logic [63:0] BB   = 64'(BURST_LEN + 1) << 6;
  localparam logic [7:0]  LAST = 8'(BURST_LEN);
  state_t      state, state_n;
  logic [63:0] addr_n;
  logic [7:0]  beat, beat_n;
  logic        stop, stop_n, err_n;
  logic        unused_bid;
  assign unused_bid = ^bid;
  // All handshake outputs derive from registered state only
  assign scrb_state = state;
  assign scrb_done  = state == DONE;
  assign awid       = AXI_ID;
  assign awaddr     = scrb_addr;
  assign awlen      = LAST;
  assign awsize     = 3'd6;
  assign awvalid    = state == ADDR;
  assign wid        = AXI_ID;
  assign wdata      = '0;
  assign wstrb      = '1;
  assign wvalid     = state == DATA;
  assign wlast      = state == DATA && beat == LAST;
  assign bready     = state == RESP;
  // Next-state, progress address, beat count, stop request and sticky error
  always_comb begin
    state_n = state;
    addr_n  = scrb_addr;
    beat_n  = beat;
    stop_n  = stop | ~scrb_enable;
    err_n   = scrb_err;
    case (state)
      IDLE: begin
        stop_n = 1'b0;
        addr_n = '0;
        if (scrb_enable) begin
          state_n = ADDR;
          err_n   = 1'b0;
        end
      end
      ADDR: if (awready) begin
        state_n = DATA;
        beat_n  = '0;
      end
      DATA: if (wready) begin
        beat_n  = beat + 8'd1;
        state_n = beat == LAST ? RESP : DATA;
      end
      RESP: if (bvalid) begin
        err_n = scrb_err | (bresp != 2'b00);
        if (scrb_addr + BB == MAX_ADDR) begin
          state_n = DONE;
          addr_n  = MAX_ADDR;
        end else if (stop_n) begin
          state_n = IDLE;
          addr_n  = '0;
        end else begin
          state_n = ADDR;
          addr_n  = scrb_addr + BB;
        end
      end
      DONE: begin
        stop_n = stop;
        if (!scrb_enable) begin
          state_n = IDLE;
          addr_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      scrb_addr <= '0;
      beat      <= '0;
      stop      <= 1'b0;
      scrb_err  <= 1'b0;
    end else begin
      state     <= state_n;
      scrb_addr <= addr_n;
      beat      <= beat_n;
      stop      <= stop_n;
      scrb_err  <= err_n;
    end
  end
endmodule

// File: tb/tb_vsi_dram_scrubber.sv
// tb_vsi_dram_scrubber: randomized self-checking bench with a transaction-level model
module tb_vsi_dram_scrubber;
  localparam logic [63:0] MAXA = 64'h4000;
  localparam int          BL   = 63;
  localparam logic [63:0] BB   = 64'((BL + 1) * 64);
  logic         clk = 0, rst = 1, scrb_enable = 0;
  logic [63:0]  scrb_addr;
  logic [2:0]   scrb_state;
  logic         scrb_done, scrb_err;
  logic [15:0]  awid, wid, bid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid, awready = 0;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast, wvalid, wready = 0;
  logic [1:0]   bresp = 0;
  logic         bvalid = 0, bready;
  int checks = 0, errors = 0;
  int aw_cnt = 0, b_cnt = 0, beat = 0, bad_b = -1, n;
  logic bp = 0, exp_err = 0, aw_pend = 0;
  logic [63:0] aw_hold;
  assign bid = 16'h5a5a;
  vsi_dram_scrubber #(.MAX_ADDR(MAXA), .BURST_LEN(BL), .AXI_ID(16'h0)) dut (
    .clk(clk), .rst(rst), .scrb_enable(scrb_enable), .scrb_addr(scrb_addr),
    .scrb_state(scrb_state), .scrb_done(scrb_done), .scrb_err(scrb_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
    .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Observe the handshakes of the coming edge, advance one clock, drive new inputs
  task automatic cyc();
    if (awvalid === 1'b1) begin
      check("aw_w_excl", 64'(wvalid), 0);
      if (aw_pend) check("aw_stable", awaddr, aw_hold);
      if (awready) begin
        check("awaddr", awaddr, 64'(aw_cnt) * BB);
        check("aw_attr", {awid, awlen, awsize}, {16'h0, 8'(BL), 3'd6});
        aw_cnt++;
        beat = 0;
        aw_pend = 0;
      end else begin
        aw_pend = 1;
        aw_hold = awaddr;
      end
    end
    if (wvalid === 1'b1) begin
      check("wlast", 64'(wlast), 64'(beat == BL));
      if (wready) begin
        check("wzero", 64'(wdata == 0 && &wstrb && wid == 0), 1);
        beat++;
      end
    end
    if (bready === 1'b1 && bvalid) begin
      check("beats", 64'(beat), 64'(BL + 1));
      if (bresp != 0) exp_err = 1;
      b_cnt++;
    end
    @(posedge clk);
    #1;
    check("err", 64'(scrb_err), 64'(exp_err));
    awready = !bp || $urandom_range(1) == 1;
    wready  = !bp || $urandom_range(1) == 1;
    bvalid  = !bp || $urandom_range(1) == 1;
    bresp   = b_cnt == bad_b ? 2'b10 : 2'b00;
  endtask
  task automatic start();
    aw_cnt = 0;
    b_cnt = 0;
    beat = 0;
    aw_pend = 0;
    exp_err = 0;
    scrb_enable = 1;
    cyc();
    check("start_awvalid", 64'(awvalid), 1);
    check("start_addr", awaddr, 0);
  endtask
  task automatic run_to_done(input string tag, input int budget);
    n = 0;
    while (!scrb_done && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_done"}, 64'(scrb_done), 1);
    check({tag, "_bursts"}, 64'(aw_cnt), 4);
    check({tag, "_addr"}, scrb_addr, MAXA);
    check({tag, "_state"}, 64'(scrb_state), 4);
  endtask
  initial begin
    cyc();
    cyc();
    check("rst_outs", {61'(scrb_addr), scrb_state}, 0);
    check("rst_flags", {awvalid, wvalid, wlast, bready, scrb_done, scrb_err}, 0);
    rst = 0;
    cyc();
    check("idle_hold", {awvalid, 3'(scrb_state)}, 0);
    start();
    run_to_done("full", 2000);
    check("full_cycles", 64'(n), 4 * (BL + 3));
    for (int i = 0; i < 100; i++) cyc();
    check("hold_no_aw", 64'(aw_cnt), 4);
    check("hold_done", 64'(scrb_done), 1);
    scrb_enable = 0;
    cyc();
    check("drop_done", 64'(scrb_done), 0);
    check("drop_state", 64'(scrb_state), 0);
    check("drop_addr", scrb_addr, 0);
    bp = 1;
    bad_b = 2;
    start();
    run_to_done("bp_err", 20000);
    check("err_at_done", 64'(scrb_err), 1);
    scrb_enable = 0;
    cyc();
    check("err_sticky_idle", 64'(scrb_err), 1);
    bp = 0;
    bad_b = -1;
    start();
    check("err_cleared", 64'(scrb_err), 0);
    n = 0;
    while (!(aw_cnt == 2 && beat == 10) && n < 1000) begin
      cyc();
      n++;
    end
    check("stop_reach", 64'(aw_cnt == 2 && beat == 10), 1);
    scrb_enable = 0;
    n = 0;
    while (scrb_state != 0 && n < 1000) begin
      cyc();
      n++;
    end
    check("stop_cycles", 64'(n), 64'(BL + 1 - 10 + 1));
    check("stop_bursts", 64'(b_cnt), 2);
    check("stop_addr", scrb_addr, 0);
    for (int i = 0; i < 20; i++) cyc();
    check("stop_no_aw", 64'(aw_cnt), 2);
    check("stop_done", 64'(scrb_done), 0);
    bp = 1;
    start();
    n = 0;
    while (!(aw_cnt == 1 && beat == 20 && wvalid) && n < 2000) begin
      cyc();
      n++;
    end
    check("rst_reach", 64'(aw_cnt == 1 && beat == 20), 1);
    rst = 1;
    exp_err = 0;
    cyc();
    check("midrst_valids", {awvalid, wvalid, wlast, bready}, 0);
    check("midrst_state", 64'(scrb_state), 0);
    check("midrst_addr", scrb_addr, 0);
    rst = 0;
    aw_cnt = 0;
    b_cnt = 0;
    beat = 0;
    aw_pend = 0;
    cyc();
    check("rerun_awvalid", 64'(awvalid), 1);
    check("rerun_addr", awaddr, 0);
    run_to_done("rerun", 20000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
